// File: rtl/multi_pattern_pwm.sv
// Multi-channel pattern PWM: each channel plays a bit pattern, holding each bit for
// 'duty' cycles, then idles for 'gap' cycles, repeating 'num' times (0 = forever).
module multi_pattern_pwm #(
  parameter int CH_NUM     = 4,
  parameter int _PAT_WIDTH = 16,
  parameter int _GAP_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [CH_NUM-1:0]     pwm_en,
  input  logic                  start,
  input  logic                  cfg_wr,
  input  logic [2:0]            cfg_ch,
  input  logic [7:0]            cfg_duty,
  input  logic [_GAP_WIDTH-1:0] cfg_gap,
  input  logic [7:0]            cfg_num,
  input  logic [_PAT_WIDTH-1:0] cfg_pat,
  input  logic                  cfg_inv,
  output logic [CH_NUM-1:0]     pwm_out,
  output logic [CH_NUM-1:0]     busy,
  output logic [CH_NUM-1:0]     valid
);

  localparam int BIT_W = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(_PAT_WIDTH - 1);
  localparam logic [_GAP_WIDTH-1:0] GAP_ONE  = {{(_GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [_GAP_WIDTH-1:0] GAP_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAT,
    ST_GAP,
    ST_DONE
  } state_t;

  for (genvar i = 0; i < CH_NUM; i++) begin : gen_ch
    state_t                  r_state;
    logic [7:0]              r_shDuty;
    logic [_GAP_WIDTH-1:0]   r_shGap;
    logic [7:0]              r_shNum;
    logic [_PAT_WIDTH-1:0]   r_shPat;
    logic                    r_shInv;
    logic [7:0]              r_actDuty;
    logic [_GAP_WIDTH-1:0]   r_actGap;
    logic [7:0]              r_actNum;
    logic [_PAT_WIDTH-1:0]   r_actPat;
    logic                    r_actInv;
    logic [7:0]              r_dutyCnt;
    logic [_GAP_WIDTH-1:0]   r_gapCnt;
    logic [BIT_W-1:0]        r_bitIdx;
    logic [7:0]              r_pulseCnt;
    logic                    r_pwm;
    logic                    r_busy;
    logic                    r_valid;

    logic                    w_wrSel;
    logic [7:0]              w_dutyLast;
    logic                    w_dutyEnd;
    logic                    w_lastBit;
    logic [BIT_W-1:0]        w_nextBit;
    logic                    w_pulseEnd;
    logic                    w_reachedNum;
    logic                    w_load;

    // A channel index outside 0..CH_NUM-1 never matches any generated channel.
    assign w_wrSel    = cfg_wr && (cfg_ch == 3'(i));
    assign w_dutyLast = (r_actDuty == 8'd0) ? 8'd0 : r_actDuty - 8'd1;
    assign w_dutyEnd  = (r_dutyCnt == w_dutyLast);
    assign w_lastBit  = (r_bitIdx == LAST_BIT);
    assign w_nextBit  = r_bitIdx + BIT_W'(1);

    assign w_pulseEnd = ((r_state == ST_PAT) && w_dutyEnd && w_lastBit && (r_actGap == GAP_ZERO)) ||
                        ((r_state == ST_GAP) && (r_gapCnt == r_actGap - GAP_ONE));
    assign w_reachedNum = (r_actNum != 8'd0) && ((r_pulseCnt + 8'd1) == r_actNum);
    assign w_load       = ((r_state == ST_IDLE) && start) || (w_pulseEnd && !w_reachedNum);

    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        r_state    <= ST_IDLE;
        r_shDuty   <= 8'd1;
        r_shGap    <= '0;
        r_shNum    <= 8'd0;
        r_shPat    <= '0;
        r_shInv    <= 1'b0;
        r_actDuty  <= 8'd1;
        r_actGap   <= '0;
        r_actNum   <= 8'd0;
        r_actPat   <= '0;
        r_actInv   <= 1'b0;
        r_dutyCnt  <= 8'd0;
        r_gapCnt   <= '0;
        r_bitIdx   <= '0;
        r_pulseCnt <= 8'd0;
        r_pwm      <= 1'b0;
        r_busy     <= 1'b0;
        r_valid    <= 1'b0;
      end else begin
        if (w_wrSel) begin
          r_shDuty <= cfg_duty;
          r_shGap  <= cfg_gap;
          r_shNum  <= cfg_num;
          r_shPat  <= cfg_pat;
          r_shInv  <= cfg_inv;
        end
        r_valid <= 1'b0;
        if (!pwm_en[i]) begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_pwm      <= r_shInv;
          r_dutyCnt  <= 8'd0;
          r_gapCnt   <= '0;
          r_bitIdx   <= '0;
          r_pulseCnt <= 8'd0;
        end else if (w_load) begin
          // Reload reads the pre-write shadow, so a same-cycle write lands one pulse later.
          r_actDuty <= r_shDuty;
          r_actGap  <= r_shGap;
          r_actNum  <= r_shNum;
          r_actPat  <= r_shPat;
          r_actInv  <= r_shInv;
          r_state   <= ST_PAT;
          r_bitIdx  <= '0;
          r_dutyCnt <= 8'd0;
          r_gapCnt  <= '0;
          r_pwm     <= r_shPat[0] ^ r_shInv;
          r_busy    <= 1'b1;
          if (r_state == ST_IDLE) begin
            r_pulseCnt <= 8'd0;
          end else if (r_actNum != 8'd0) begin
            r_pulseCnt <= r_pulseCnt + 8'd1;
          end
        end else if (w_pulseEnd) begin
          r_state    <= ST_DONE;
          r_valid    <= 1'b1;
          r_busy     <= 1'b0;
          r_pwm      <= r_actInv;
          r_pulseCnt <= 8'd0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              r_pwm <= r_shInv;
            end
            ST_PAT: begin
              if (w_dutyEnd) begin
                r_dutyCnt <= 8'd0;
                if (w_lastBit) begin
                  r_state  <= ST_GAP;
                  r_gapCnt <= '0;
                  r_pwm    <= r_actInv;
                end else begin
                  r_bitIdx <= w_nextBit;
                  r_pwm    <= r_actPat[w_nextBit] ^ r_actInv;
                end
              end else begin
                r_dutyCnt <= r_dutyCnt + 8'd1;
              end
            end
            ST_GAP: begin
              r_gapCnt <= r_gapCnt + GAP_ONE;
            end
            ST_DONE: begin
              r_state <= ST_IDLE;
              r_pwm   <= r_shInv;
            end
            default: begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_pwm   <= r_shInv;
            end
          endcase
        end
      end
    end

    assign pwm_out[i] = r_pwm;
    assign busy[i]    = r_busy;
    assign valid[i]   = r_valid;
  end

endmodule
